// File: rtl/alu_pipe_pkg.sv
// Shared widths, skid FSM states and payload packing offsets for the
// decode-to-ALU pipeline register.
package alu_pipe_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC7_W  = 7;
  localparam int unsigned FUNC3_W  = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic int unsigned payload_w(input int unsigned xlen,
                                            input int unsigned imm_w,
                                            input int unsigned rd_w);
    return OPCODE_W + FUNC7_W + FUNC3_W + 3 * xlen + imm_w + rd_w;
  endfunction

  // Layout from LSB: rd, imm, pc, rs2, rs1, func3, func7, opcode
  function automatic int unsigned off_pc(input int unsigned imm_w,
                                         input int unsigned rd_w);
    return rd_w + imm_w;
  endfunction

  function automatic int unsigned off_rs2(input int unsigned xlen,
                                          input int unsigned imm_w,
                                          input int unsigned rd_w);
    return off_pc(imm_w, rd_w) + xlen;
  endfunction

  function automatic int unsigned off_rs1(input int unsigned xlen,
                                          input int unsigned imm_w,
                                          input int unsigned rd_w);
    return off_pc(imm_w, rd_w) + 2 * xlen;
  endfunction

  function automatic int unsigned off_func3(input int unsigned xlen,
                                            input int unsigned imm_w,
                                            input int unsigned rd_w);
    return off_pc(imm_w, rd_w) + 3 * xlen;
  endfunction

  function automatic int unsigned off_func7(input int unsigned xlen,
                                            input int unsigned imm_w,
                                            input int unsigned rd_w);
    return off_func3(xlen, imm_w, rd_w) + FUNC3_W;
  endfunction

  function automatic int unsigned off_opcode(input int unsigned xlen,
                                             input int unsigned imm_w,
                                             input int unsigned rd_w);
    return off_func7(xlen, imm_w, rd_w) + FUNC7_W;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline slot on a flat vector with flush; optional
// skid entry so upstream ready depends only on registered state.
module pipe_skid_buf
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  if (SKID) begin : g_skid
    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] m_q, s_q;
    logic              accept, issue;
    logic              load_m_in, load_m_skid, load_s;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_q;
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
    end

    // Flush wins over any accept; the skid entry is always older than M's reload
    always_comb begin
      state_d     = state_q;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (accept) begin
            state_d   = ST_BUSY;
            load_m_in = 1'b1;
          end
          ST_BUSY: begin
            if (accept && issue) begin
              load_m_in = 1'b1;
            end else if (accept) begin
              state_d = ST_FULL;
              load_s  = 1'b1;
            end else if (issue) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: if (issue) begin
            state_d     = ST_BUSY;
            load_m_skid = 1'b1;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_q <= '0;
        s_q <= '0;
      end else begin
        if (load_m_in)        m_q <= in_data;
        else if (load_m_skid) m_q <= s_q;
        if (load_s)           s_q <= in_data;
      end
    end
  end else begin : g_single
    logic              v_q;
    logic [DATA_W-1:0] m_q;
    logic              accept;

    assign in_ready  = !v_q || out_ready;
    assign out_valid = v_q;
    assign out_data  = m_q;
    assign accept    = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        m_q <= '0;
      end else begin
        if (flush)                      v_q <= 1'b0;
        else if (accept)                v_q <= 1'b1;
        else if (out_valid && out_ready) v_q <= 1'b0;
        if (accept) m_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_reg.sv
// Decode-to-ALU pipeline register: packs the decoded bundle into a flat
// payload, runs it through a valid/ready slot and unpacks it for the ALU.
module alu_pipe_reg
  import alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned IMM_W = 20,
  parameter int unsigned RD_W  = 5,
  parameter bit          SKID  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                i_valid,
  output logic                i_ready_o,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC7_W-1:0]  func7,
  input  logic [FUNC3_W-1:0]  func3,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [IMM_W-1:0]    imm,
  input  logic [XLEN-1:0]     pc,
  input  logic [RD_W-1:0]     i_rd_indx,
  output logic                r_i_valid,
  input  logic                r_ready,
  output logic [OPCODE_W-1:0] r_opcode,
  output logic [FUNC7_W-1:0]  r_func7,
  output logic [FUNC3_W-1:0]  r_func3,
  output logic [XLEN-1:0]     r_rs1,
  output logic [XLEN-1:0]     r_rs2,
  output logic [IMM_W-1:0]    r_imm,
  output logic [XLEN-1:0]     r_pc,
  output logic [RD_W-1:0]     r_i_rd_indx
);

  localparam int unsigned DATA_W   = payload_w(XLEN, IMM_W, RD_W);
  localparam int unsigned O_PC     = off_pc(IMM_W, RD_W);
  localparam int unsigned O_RS2    = off_rs2(XLEN, IMM_W, RD_W);
  localparam int unsigned O_RS1    = off_rs1(XLEN, IMM_W, RD_W);
  localparam int unsigned O_FUNC3  = off_func3(XLEN, IMM_W, RD_W);
  localparam int unsigned O_FUNC7  = off_func7(XLEN, IMM_W, RD_W);
  localparam int unsigned O_OPCODE = off_opcode(XLEN, IMM_W, RD_W);

  logic [DATA_W-1:0] in_data, out_data;

  assign in_data = {opcode, func7, func3, rs1, rs2, pc, imm, i_rd_indx};

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .SKID   (SKID)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (i_valid),
    .in_ready  (i_ready_o),
    .in_data   (in_data),
    .out_valid (r_i_valid),
    .out_ready (r_ready),
    .out_data  (out_data)
  );

  assign r_i_rd_indx = out_data[0 +: RD_W];
  assign r_imm       = out_data[RD_W +: IMM_W];
  assign r_pc        = out_data[O_PC +: XLEN];
  assign r_rs2       = out_data[O_RS2 +: XLEN];
  assign r_rs1       = out_data[O_RS1 +: XLEN];
  assign r_func3     = out_data[O_FUNC3 +: FUNC3_W];
  assign r_func7     = out_data[O_FUNC7 +: FUNC7_W];
  assign r_opcode    = out_data[O_OPCODE +: OPCODE_W];

endmodule

// File: doc/alu_pipe_reg.md
Name: alu_pipe_reg

Overview:
Parametrised decode-to-ALU pipeline register with a valid/ready handshake, a flush input and asynchronous reset; successor to the plain always-enabled decode/ALU register.
- Carries the decoded instruction bundle (opcode, func7, func3, rs1, rs2, imm, pc, rd index) from register read to the ALU stage.
- Supports back-pressure via an optional skid slot, so upstream ready is a registered signal.
- Sits between reg_file read and the ALU.

Parameters:
XLEN, 64, width of rs1/rs2/pc data.
IMM_W, 20, immediate field width.
RD_W, 5, destination register index width.
SKID, 1, 1 = two-entry skid buffer with registered i_ready_o; 0 = single-entry register with combinational i_ready_o.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all held entries (branch redirect / trap).
i_valid  in  1  upstream bundle valid.
i_ready_o  out  1  stage can accept a bundle this cycle.
opcode  in  7  decoded opcode.
func7  in  7  funct7.
func3  in  3  funct3.
rs1  in  XLEN  source operand 1.
rs2  in  XLEN  source operand 2.
imm  in  IMM_W  immediate.
pc  in  XLEN  instruction PC.
i_rd_indx  in  RD_W  destination register index.
r_i_valid  out  1  downstream bundle valid.
r_ready  in  1  ALU accepts the bundle.
r_opcode, r_func7, r_func3, r_rs1, r_rs2, r_imm, r_pc, r_i_rd_indx  out  (matching widths)  registered bundle.

Behaviour:
- Handshakes:
  - Accept (upstream) = i_valid & i_ready_o.
  - Issue (downstream) = r_i_valid & r_ready.
  - Payload is captured only on accept and never changes while r_i_valid=1 and r_ready=0.
- Reset (rst_n=0, asynchronous):
  - r_i_valid=0 and all r_* payload outputs = 0.
  - Skid slot emptied and zeroed.
  - i_ready_o=1 from release onward.
- Latency: an accept at edge N drives r_i_valid=1 with the bundle after edge N. Throughput is 1 bundle/cycle while r_ready=1.
- SKID=1 state machine, built from main slot M and skid slot S:
  - EMPTY (M=0, S=0): accept -> BUSY.
  - BUSY (M=1, S=0):
    - accept & issue -> BUSY (M reloads).
    - accept & !issue -> FULL (bundle goes to S).
    - !accept & issue -> EMPTY.
  - FULL (M=1, S=1): i_ready_o=0. Issue -> BUSY with S moved into M (same edge). No accept possible.
  - i_ready_o = !S, registered; no combinational path from r_ready to i_ready_o.
- SKID=0:
  - Single slot.
  - i_ready_o = !r_i_valid | r_ready (combinational).
  - Same-cycle issue and accept reloads the slot.
- Ordering: strict FIFO; S is always older than any newly accepted bundle.
- Flush:
  - At the edge, M and S valid bits clear regardless of state.
  - Any same-cycle accept is dropped; flush has priority.
  - State -> EMPTY and i_ready_o=1 next cycle.
  - Payload registers keep their stale values; only valid bits matter.
- Simultaneous flush and r_ready: the issue still completes this cycle (the ALU sampled it), then the stage is empty.
- Reset mid-operation: all in-flight bundles are discarded; no partial payload survives.
- Payload is passed through unmodified: no sign extension or width conversion.

Decomposition:
- Package alu_pipe_pkg holds:
  - Field widths OPCODE_W=7, FUNC7_W=7, FUNC3_W=3.
  - The payload width function PAYLOAD_W = 17 + 3*XLEN + IMM_W + RD_W (234 at defaults).
  - Pack/unpack field offsets.
- Sub-module pipe_skid_buf (DATA_W, SKID) implements the generic valid/ready/flush slot logic on a flat vector.
- alu_pipe_reg only packs and unpacks fields.

Test Plan:
- Reset:
  - Drive rst_n=0 mid-stream with r_i_valid=1 -> all outputs 0 immediately (before next edge).
  - After release, i_ready_o=1.
- Streaming, r_ready=1: send 4 bundles with pc=0x1000,0x1004,0x1008,0x100C, opcode=0x33 -> each appears 1 cycle later, back-to-back, in order, fields bit-exact.
- Back-pressure (SKID=1):
  - Hold r_ready=0 and send pc=0x2000, 0x2004 -> r_pc stays 0x2000, then i_ready_o=0.
  - Release r_ready -> 0x2000 then 0x2004 are issued; i_ready_o=1 one cycle after the skid drains.
- Flush: in FULL state, assert flush with i_valid=1 and pc=0x3000 -> next cycle r_i_valid=0, i_ready_o=1, and 0x3000 never issued.
- SKID=0 build: r_ready=0 with r_i_valid=1 -> i_ready_o=0 combinationally; r_ready=1 in the same cycle as an accept -> new bundle replaces old one with no bubble.
- Wide data: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0x8000_0000_0000_0001, imm=0xFFFFF, i_rd_indx=31 -> identical values on r_* outputs.
